// File: rtl/axil_regbank.sv
// axil_regbank: parametrised AXI4-Lite slave register bank.
// Provides NUM_REGS registers of DATA_WIDTH bits with byte-strobed writes,
// read-only status registers (RO_MASK), SLVERR on decode misses and a
// one-cycle write pulse per accepted write.
// Optional feature macro: AXIL_RB_W1C_EN enables write-1-to-clear registers
// (W1C_MASK) that hardware can set through hw_set.
module axil_regbank #(
    parameter int                      DATA_WIDTH  = 32,
    parameter int                      ADDR_WIDTH  = 6,
    parameter int                      NUM_REGS    = 8,
    parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]     W1C_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                r_wstate;
    w_state_t                w_wstate_nxt;
    r_state_t                r_rstate;
    r_state_t                w_rstate_nxt;
    logic                    r_run;
    logic [IDX_W-1:0]        r_awidx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [1:0]              r_bresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic [NUM_REGS-1:0]     r_wr_pulse;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_wr_fire;
    logic [IDX_W-1:0]        w_widx;
    logic [IDX_W-1:0]        w_ridx;
    logic                    w_widx_ok;
    logic                    w_ridx_ok;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [STRB_W-1:0]       w_wstrb;
    logic [DATA_WIDTH-1:0]   w_bmask;
    logic [DATA_WIDTH-1:0]   w_rd_val;
    logic [NUM_REGS-1:0]     w_hit;
    logic                    w_unused;

    // Channel readiness is gated by r_run so every READY stays low in reset
    // and rises on the first clock edge after release.
    assign AWREADY  = r_run && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    assign WREADY   = r_run && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    assign BVALID   = (r_wstate == W_RESP);
    assign BRESP    = r_bresp;
    assign ARREADY  = r_run && (r_rstate == R_IDLE);
    assign RVALID   = (r_rstate == R_DATA);
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign wr_pulse = r_wr_pulse;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    // Address/data of the completing write: stored copy when that channel
    // arrived earlier, live bus value when it arrives on this edge.
    assign w_widx    = (r_wstate == W_HAVE_AW) ? r_awidx : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign w_wdata   = (r_wstate == W_HAVE_W)  ? r_wdata : WDATA;
    assign w_wstrb   = (r_wstate == W_HAVE_W)  ? r_wstrb : WSTRB;
    assign w_ridx    = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign w_widx_ok = {1'b0, w_widx} < NUM_REGS_L;
    assign w_ridx_ok = {1'b0, w_ridx} < NUM_REGS_L;

    // Expand byte strobes into a bit mask.
    always_comb begin
        for (int b = 0; b < STRB_W; b++) begin
            w_bmask[b*8 +: 8] = {8{w_wstrb[b]}};
        end
    end

    // Per-register write enable for an accepted write to a writable register.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i] = w_wr_fire && (w_widx == IDX_W'(i)) && !RO_MASK[i];
        end
    end

    // Read mux: status input for RO registers, stored value otherwise; 0 on a miss.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ridx == IDX_W'(i)) begin
                w_rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    // Write FSM next state; AW and W may complete in either order or together.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_wstate_nxt = r_wstate;
        w_wr_fire    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wr_fire    = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_wr_fire    = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_wr_fire    = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (RREADY)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Run flag: enables the READY outputs one edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!ARESETN) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Write channel state, captured AW/W halves, response and write pulses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate   <= W_IDLE;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_wr_pulse <= w_hit;
            if (w_aw_hs) begin
                r_awidx <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_wr_fire) begin
                r_bresp <= w_widx_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read channel state and registered response, held until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_ridx_ok ? w_rd_val : '0;
                r_rresp <= w_ridx_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register storage: byte-lane merge for RW, clear/set for W1C registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            // NOTE: this array is a bank of control flops, not a RAM, so it is
            // reset explicitly; a RAM-style array would be left unreset.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
`ifdef AXIL_RB_W1C_EN
                if (W1C_MASK[i] && !RO_MASK[i]) begin
                    // Hardware set is OR-ed after the clear so it wins a same-cycle race.
                    r_regs[i] <= (r_regs[i] & ~(w_wdata & w_bmask & {DATA_WIDTH{w_hit[i]}}))
                                 | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
                end else
`endif
                if (w_hit[i]) begin
                    r_regs[i] <= (r_regs[i] & ~w_bmask) | (w_wdata & w_bmask);
                end
            end
        end
    end

    // Flattened register view; RO slots mirror their status input.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? status_in[g*DATA_WIDTH +: DATA_WIDTH] : r_regs[g];
    end

    // Inputs with no function in this configuration.
`ifdef AXIL_RB_W1C_EN
    assign w_unused = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};
`else
    assign w_unused = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0],
                        hw_set, W1C_MASK};
`endif

endmodule
